// File: rtl/pipe_perf_monitor.sv
// Cycle and pipeline-event counters with a programmable cycle limit, plus a
// snapshot engine that streams frozen copies of every counter over valid/ready.
module pipe_perf_monitor #(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0,
    parameter int IDX_W    = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [CNT_W-1:0]   limit_i,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o,
    input  logic               snap_req_i,
    output logic               snap_busy_o,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [IDX_W-1:0]   rd_idx_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_last_o
);

    localparam logic [CNT_W-1:0] ONES     = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVT);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    // Slot 0 is the cycle counter, slot k is event k-1; same layout as ovf_o.
    logic [CNT_W-1:0] cnt_q    [NUM_EVT+1];
    logic [CNT_W-1:0] cnt_d    [NUM_EVT+1];
    logic [CNT_W-1:0] shadow_q [NUM_EVT+1];
    logic [NUM_EVT:0] ovf_q;
    logic [NUM_EVT:0] ovf_d;
    logic [NUM_EVT:0] inc;
    logic [IDX_W-1:0] idx_q;
    state_t           state_q;
    logic             done;
    logic             active;

    assign done   = (limit_i != '0) && (cnt_q[0] >= limit_i);
    assign active = start_i && !done;
    assign inc    = {evt_i, 1'b1} & {(NUM_EVT + 1){active}};

    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k <= NUM_EVT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clear_i) begin
                cnt_d[k] = '0;
            end else if (inc[k]) begin
                if (cnt_q[k] == ONES) begin
                    ovf_d[k] = 1'b1;
                    cnt_d[k] = (SATURATE != 0) ? ONES : '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + ONE;
                end
            end
        end
        if (clear_i) begin
            ovf_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k <= NUM_EVT; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k <= NUM_EVT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    // Readout handshake: a beat transfers on a rising edge where rd_valid_o and
    // rd_ready_i are both high; while valid is high and ready low, idx/data/last
    // are held, and valid never drops without a transfer except on reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            for (int k = 0; k <= NUM_EVT; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (snap_req_i) begin
                        for (int k = 0; k <= NUM_EVT; k++) begin
                            shadow_q[k] <= cnt_q[k];
                        end
                        idx_q   <= '0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (rd_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done_o      = done;
    assign ovf_o       = ovf_q;
    assign snap_busy_o = (state_q == S_SEND);
    assign rd_valid_o  = (state_q == S_SEND);
    assign rd_idx_o    = idx_q;
    assign rd_data_o   = shadow_q[idx_q];
    assign rd_last_o   = rd_valid_o && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Scoreboard bench for pipe_perf_monitor: snapshot beats are checked against an
// expected queue, and two 8-bit instances cover wrap versus saturate.
module tb_pipe_perf_monitor;

    localparam int NUM_EVT = 4;
    localparam int CNT_W   = 32;
    localparam int IDX_W   = $clog2(NUM_EVT + 1);
    localparam int SB_W    = IDX_W + 1 + CNT_W;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic               clear_i;
    logic [NUM_EVT-1:0] evt_i;
    logic [CNT_W-1:0]   limit_i;
    logic               snap_req_i;
    logic               rd_ready_i;
    logic               done_o;
    logic [NUM_EVT:0]   ovf_o;
    logic               snap_busy_o;
    logic               rd_valid_o;
    logic [IDX_W-1:0]   rd_idx_o;
    logic [CNT_W-1:0]   rd_data_o;
    logic               rd_last_o;

    logic               snap_req_s;
    logic               ready_s = 1'b1;
    logic [7:0]         limit8 = 8'h00;
    logic               done_w, busy_w, valid_w, last_w;
    logic               done_s, busy_s, valid_s, last_s;
    logic [NUM_EVT:0]   ovf_w, ovf_s;
    logic [IDX_W-1:0]   idx_w, idx_s;
    logic [7:0]         data_w, data_s;

    int n_checks = 0;
    int n_fail   = 0;
    int beats    = 0;

    logic [SB_W-1:0]  exp_q[$];
    logic [CNT_W-1:0] m_cnt [NUM_EVT+1];
    logic [SB_W-1:0]  mon_obs;
    logic [SB_W-1:0]  mon_exp;
    logic [SB_W-1:0]  prev_beat;
    logic             prev_stall = 1'b0;

    always #5 clk_i = ~clk_i;

    pipe_perf_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .SATURATE(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .evt_i(evt_i), .limit_i(limit_i), .done_o(done_o), .ovf_o(ovf_o),
        .snap_req_i(snap_req_i), .snap_busy_o(snap_busy_o), .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i), .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o),
        .rd_last_o(rd_last_o)
    );

    pipe_perf_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(8), .SATURATE(0)) dut_wrap8 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .evt_i(evt_i), .limit_i(limit8), .done_o(done_w), .ovf_o(ovf_w),
        .snap_req_i(snap_req_s), .snap_busy_o(busy_w), .rd_valid_o(valid_w),
        .rd_ready_i(ready_s), .rd_idx_o(idx_w), .rd_data_o(data_w),
        .rd_last_o(last_w)
    );

    pipe_perf_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(8), .SATURATE(1)) dut_sat8 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .evt_i(evt_i), .limit_i(limit8), .done_o(done_s), .ovf_o(ovf_s),
        .snap_req_i(snap_req_s), .snap_busy_o(busy_s), .rd_valid_o(valid_s),
        .rd_ready_i(ready_s), .rd_idx_o(idx_s), .rd_data_o(data_s),
        .rd_last_o(last_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k <= NUM_EVT; k++) m_cnt[k] = '0;
    endtask

    // One clock: the reference counts are updated from the inputs seen at the edge.
    task automatic step();
        logic m_done;
        m_done = (limit_i != '0) && (m_cnt[0] >= limit_i);
        @(posedge clk_i);
        if (!rst_i || clear_i) begin
            m_reset();
        end else if (start_i && !m_done) begin
            m_cnt[0] = m_cnt[0] + 1;
            for (int k = 0; k < NUM_EVT; k++)
                if (evt_i[k]) m_cnt[k+1] = m_cnt[k+1] + 1;
        end
        #2;
    endtask

    task automatic push_beat(input int k, input logic [CNT_W-1:0] val);
        logic [IDX_W-1:0] i;
        i = k[IDX_W-1:0];
        exp_q.push_back({i, (k == NUM_EVT), val});
    endtask

    task automatic push_model();
        for (int k = 0; k <= NUM_EVT; k++) push_beat(k, m_cnt[k]);
    endtask

    task automatic rand_evt();
        evt_i = NUM_EVT'($urandom_range(0, (1 << NUM_EVT) - 1));
    endtask

    task automatic drain(input string tag, input bit toggle, input bit rnd);
        int n;
        n = 0;
        rd_ready_i = 1'b1;
        while ((exp_q.size() != 0 || rd_valid_o) && n < 60) begin
            if (rnd) rand_evt();
            step();
            if (toggle) rd_ready_i = ~rd_ready_i;
            n++;
        end
        check({tag, "_drained"}, n < 60, 1'b1);
        exp_q.delete();
        rd_ready_i = 1'b0;
        evt_i = '0;
    endtask

    // Expectations must be pushed before calling; they hold the pre-edge counts.
    task automatic do_snap(input string tag, input bit toggle, input bit rnd);
        snap_req_i = 1'b1;
        step();
        snap_req_i = 1'b0;
        drain(tag, toggle, rnd);
    endtask

    always @(negedge clk_i) begin
        mon_obs = {rd_idx_o, rd_last_o, rd_data_o};
        if (rd_valid_o && prev_stall) check("hold_stable", mon_obs, prev_beat);
        if (rd_valid_o && rd_ready_i) begin
            beats++;
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check($sformatf("beat_idx%0d", rd_idx_o), mon_obs, mon_exp);
            end
        end
        prev_stall = rd_valid_o && !rd_ready_i;
        prev_beat  = mon_obs;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        rst_i = 1'b0; start_i = 1'b0; clear_i = 1'b0; evt_i = '0; limit_i = '0;
        snap_req_i = 1'b0; rd_ready_i = 1'b0; snap_req_s = 1'b0;
        m_reset();
        repeat (3) @(posedge clk_i);
        #2;
        check("rst_done", done_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_busy", snap_busy_o, 0);
        check("rst_valid", rd_valid_o, 0);
        check("rst_idx", rd_idx_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_last", rd_last_o, 0);
        rst_i = 1'b1;
        step();

        // Free run, no events, unlimited.
        start_i = 1'b1;
        repeat (10) step();
        start_i = 1'b0;
        check("t1_done", done_o, 0);
        check("t1_ovf", ovf_o, 0);
        push_beat(0, 10);
        for (int k = 1; k <= NUM_EVT; k++) push_beat(k, 0);
        snap_req_i = 1'b1;
        rd_ready_i = 1'b1;
        step();
        snap_req_i = 1'b0;
        check("t1_valid_after_req", rd_valid_o, 1);
        check("t1_busy_after_req", snap_busy_o, 1);
        check("t1_idx0", rd_idx_o, 0);
        repeat (NUM_EVT) step();
        check("t1_busy_before_last", snap_busy_o, 1);
        step();
        check("t1_busy_after_last", snap_busy_o, 0);
        check("t1_valid_after_last", rd_valid_o, 0);
        check("t1_all_beats", exp_q.size(), 0);
        rd_ready_i = 1'b0;

        // Cycle limit of 64; events after the freeze must be ignored.
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        limit_i = 64;
        start_i = 1'b1;
        for (int c = 1; c <= 84; c++) begin
            if (c > 70) evt_i = '1;
            else evt_i = {2'b00, (c == 5), (c >= 3 && c <= 7)};
            step();
            check($sformatf("t2_done_c%0d", c), done_o, c >= 64);
        end
        start_i = 1'b0;
        evt_i = '0;
        check("t2_ovf", ovf_o, 0);
        push_beat(0, 64); push_beat(1, 5); push_beat(2, 1); push_beat(3, 0); push_beat(4, 0);
        do_snap("t2", 1'b0, 1'b0);
        limit_i = '0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t2_done_after_clear", done_o, 0);

        // 257 increments into 8-bit counters: wrap versus saturate.
        start_i = 1'b1;
        evt_i = 4'b0001;
        repeat (257) step();
        start_i = 1'b0;
        evt_i = '0;
        check("t3_wrap_ovf", ovf_w, 5'b00011);
        check("t3_sat_ovf", ovf_s, 5'b00011);
        check("t3_main_ovf", ovf_o, 0);
        snap_req_s = 1'b1;
        step();
        snap_req_s = 1'b0;
        check("t3_wrap_idx0", idx_w, 0);
        check("t3_wrap_cyc", data_w, 1);
        check("t3_sat_cyc", data_s, 255);
        step();
        check("t3_wrap_idx1", idx_w, 1);
        check("t3_wrap_evt0", data_w, 1);
        check("t3_sat_evt0", data_s, 255);
        repeat (NUM_EVT) step();
        check("t3_wrap_busy_end", busy_w, 0);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t3_wrap_ovf_cleared", ovf_w, 0);
        check("t3_sat_ovf_cleared", ovf_s, 0);

        // Random events; snapshot under ready toggling while counting continues.
        start_i = 1'b1;
        repeat (20) begin
            rand_evt();
            step();
        end
        rand_evt();
        push_model();
        b0 = beats;
        do_snap("t4", 1'b1, 1'b1);
        check("t4_beats", beats - b0, NUM_EVT + 1);
        start_i = 1'b0;
        push_model();
        do_snap("t4_live", 1'b0, 1'b0);

        // clear + event + request on one edge; a second request mid-readout.
        start_i = 1'b1;
        clear_i = 1'b1;
        evt_i = 4'b0100;
        push_model();
        b0 = beats;
        snap_req_i = 1'b1;
        step();
        clear_i = 1'b0;
        start_i = 1'b0;
        evt_i = '0;
        snap_req_i = 1'b0;
        rd_ready_i = 1'b1;
        step();
        snap_req_i = 1'b1;
        step();
        snap_req_i = 1'b0;
        drain("t5", 1'b0, 1'b0);
        repeat (3) step();
        check("t5_beats", beats - b0, NUM_EVT + 1);
        check("t5_busy", snap_busy_o, 0);
        push_beat(0, 0);
        for (int k = 1; k <= NUM_EVT; k++) push_beat(k, 0);
        do_snap("t5_cleared", 1'b0, 1'b0);

        // Reset in the middle of a readout.
        start_i = 1'b1;
        evt_i = 4'b1010;
        repeat (6) step();
        start_i = 1'b0;
        evt_i = '0;
        push_model();
        b0 = beats;
        snap_req_i = 1'b1;
        step();
        snap_req_i = 1'b0;
        rd_ready_i = 1'b1;
        n = 0;
        while (beats - b0 < 2 && n < 20) begin
            step();
            n++;
        end
        check("t6_two_beats", beats - b0, 2);
        rst_i = 1'b0;
        #1;
        check("t6_valid_async", rd_valid_o, 0);
        check("t6_busy_async", snap_busy_o, 0);
        check("t6_idx_async", rd_idx_o, 0);
        check("t6_data_async", rd_data_o, 0);
        check("t6_ovf_async", ovf_o, 0);
        exp_q.delete();
        rd_ready_i = 1'b0;
        m_reset();
        step();
        step();
        rst_i = 1'b1;
        step();
        push_beat(0, 0);
        for (int k = 1; k <= NUM_EVT; k++) push_beat(k, 0);
        do_snap("t6_post_reset", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Synthesisable per-cycle performance monitor for the 5-stage CPU. It counts elapsed cycles plus NUM_EVT pipeline events (stall, flush, retire, and so on) while the run is active, and freezes at a programmable cycle limit. On request it snapshots all counters and streams them out over a valid/ready port. Instantiated beside CPU; event bits are driven from hazard detection, IF_ID flush and MEM_WB RegWrite.

## Interface
Parameters:
- NUM_EVT, 4: number of event counters (1..15)
- CNT_W, 32: width of every counter (8..64)
- SATURATE, 0: 0 = counters wrap, 1 = counters saturate at all-ones
- IDX_W, $clog2(NUM_EVT+1): width of the readout index (derived)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  counting enable, level-sensitive
- clear_i  in  1  synchronous clear of counters, overflow flags and done
- evt_i  in  NUM_EVT  event bits, one count per high cycle
- limit_i  in  CNT_W  cycle limit; 0 = unlimited; must be static while counting
- done_o  out  1  cycle counter has reached a non-zero limit
- ovf_o  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = event k-1
- snap_req_i  in  1  snapshot request pulse
- snap_busy_o  out  1  readout in progress
- rd_valid_o  out  1  readout beat valid
- rd_ready_i  in  1  readout beat accepted
- rd_idx_o  out  IDX_W  counter index of the beat (0 = cycle, k = event k-1)
- rd_data_o  out  CNT_W  counter value of the beat
- rd_last_o  out  1  beat is index NUM_EVT

## Operation
- Counters: cyc_cnt plus evt_cnt[0..NUM_EVT-1], all CNT_W bits.
- active = start_i && !done_o. While active, cyc_cnt increments every cycle and evt_cnt[k] increments when evt_i[k]=1. Any number of events may increment in the same cycle.
- Overflow: an increment from all-ones sets the corresponding ovf_o bit (sticky). SATURATE=0: counter goes to 0. SATURATE=1: counter holds all-ones.
- done_o = (limit_i != 0) && (cyc_cnt >= limit_i), derived from registers. All counting stops while done_o is high.
- clear_i zeroes all counters and ovf_o, which drops done_o. clear_i takes priority over an increment in the same cycle, so the result is 0, not 1.
- Snapshot FSM, two states:
  - IDLE: snap_req_i=1 copies cyc_cnt and all evt_cnt into shadow registers (pre-clear and pre-increment values of that edge), sets idx=0 and moves to SEND.
  - SEND: presents shadow[idx]. On rd_valid_o && rd_ready_i: if idx==NUM_EVT, go to IDLE, otherwise idx++.
- snap_req_i is ignored while in SEND; there is no queuing.
- Live counters keep counting during SEND. clear_i during SEND does not disturb the shadow registers.
- rd_data_o, rd_idx_o and rd_last_o are held stable while rd_valid_o && !rd_ready_i.
- Reset mid-readout aborts the transfer immediately: FSM goes to IDLE and rd_valid_o drops asynchronously.

## Timing
- Reset values: all counters 0, ovf_o 0, done_o 0, FSM IDLE, snap_busy_o 0, rd_valid_o 0, rd_idx_o 0, rd_data_o 0, rd_last_o 0.
- Counter latency: an event sampled at edge N is visible in the counter after edge N.
- done_o rises in the cycle after the edge where cyc_cnt reaches limit_i. cyc_cnt then holds exactly limit_i.
- Snapshot: request sampled at edge N; rd_valid_o=1 and idx 0 appear after edge N. With rd_ready_i held high, the last beat is accepted at edge N+NUM_EVT+1. snap_busy_o=rd_valid_o falls after that edge, and a new request is accepted at the following edge.
- snap_busy_o is identical to the FSM being in SEND.

## Test plan
- Reset, then start_i=1, limit_i=0, evt_i=0 for 10 cycles → cyc_cnt=10, all evt_cnt=0, done_o=0, ovf_o=0.
- limit_i=64, start_i=1, evt_i[0] high on cycles 3..7 and evt_i[1] high on cycle 5 → done_o rises when cyc_cnt=64; evt_cnt[0]=5, evt_cnt[1]=1; the counters stay frozen for 20 more cycles.
- CNT_W=8: drive evt_i[0] high for 257 cycles. With SATURATE=0 → evt_cnt[0]=1 and ovf_o[1]=1. With SATURATE=1 → evt_cnt[0]=255 and ovf_o[1]=1.
- Snapshot with rd_ready_i toggling 1,0,1,0 (NUM_EVT=4) → 5 beats with idx 0..4 and rd_last_o only on idx 4. Data is held through the ready-low cycles, and the values equal the counts at the request edge, not the live values.
- clear_i and evt_i[2] high at the same edge as snap_req_i → shadow shows the pre-clear counts and the live evt_cnt[2]=0. A second snap_req_i during SEND is ignored (exactly 5 beats total).
- rst_i low mid-SEND after beat 2 → rd_valid_o=0 immediately, all counters 0. After reset release, a new snapshot returns all zeros.
